semaforo_cruzamento_ctrl: RTL
=============================

SEMAFORO_CRUZAMENTO_CTRL -- requirements
Module: semaforo_cruzamento_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameters, one per line: name, default, meaning:
- T_GRN_MIN, 4, minimum green cycles, either road.
- T_GRN_MAX, 8, maximum green cycles, side road B.
- T_YLW, 2, yellow cycles.
- T_ALLRED, 1, all-red cycles.
- T_WALK, 3, pedestrian walk cycles.
- CW, 8, phase counter width.
REQ-003 Ports, one per line: name, direction, width, meaning:
- Clock, in, 1, rising-edge clock.
- Reset, in, 1, synchronous active-high reset.
- CAR_B, in, 1, car present on side road B.
- PED, in, 1, pedestrian button; may be a single-cycle pulse.
- red_a, ylw_a, grn_a, out, 1 each, main road A lamps.
- red_b, ylw_b, grn_b, out, 1 each, side road B lamps.
- walk, out, 1, pedestrian walk lamp.

Function
REQ-004 States SHALL be: A_GRN, A_YLW, AR_A, WALK, AR_W, B_GRN, B_YLW, AR_B.
REQ-005 Outputs SHALL be Moore, decoded from the state register only:
- A_GRN: grn_a=1, red_b=1.
- A_YLW: ylw_a=1, red_b=1.
- B_GRN: red_a=1, grn_b=1.
- B_YLW: red_a=1, ylw_b=1.
- WALK: red_a=1, red_b=1, walk=1.
- AR_*: red_a=1, red_b=1.
- In every state, exactly one lamp per road SHALL be on, and walk SHALL be 1 only in WALK.
REQ-006 Counter cnt (CW bits) SHALL clear to 0 on every state change, else increment, saturating at 2^CW-1.
REQ-007 "Elapsed T" SHALL mean cnt==T-1, so a timed state lasts exactly T cycles.
REQ-008 A_GRN SHALL go to A_YLW when cnt>=T_GRN_MIN-1 and (CAR_B or ped_pend); otherwise it holds indefinitely.
REQ-009 A_YLW SHALL go to AR_A after T_YLW.
REQ-010 AR_A SHALL go, after T_ALLRED, to WALK if ped_pend, else to B_GRN.
REQ-011 WALK SHALL go to AR_W after T_WALK.
REQ-012 AR_W SHALL go, after T_ALLRED, to B_GRN if CAR_B, else to A_GRN.
REQ-013 B_GRN SHALL go to B_YLW when either:
- cnt>=T_GRN_MIN-1 and (CAR_B==0 or ped_pend), or
- cnt==T_GRN_MAX-1.
REQ-014 B_YLW SHALL go to AR_B after T_YLW; AR_B SHALL go to A_GRN after T_ALLRED.
REQ-015 ped_pend SHALL set on any cycle with PED=1 and clear on the edge that enters WALK; clear SHALL win over a simultaneous set.
REQ-016 PED asserted during WALK or AR_W SHALL set ped_pend for a later service.
REQ-017 CAR_B dropping before T_GRN_MIN in B_GRN SHALL NOT shorten B_GRN below T_GRN_MIN.
REQ-018 Inputs SHALL be sampled on the rising edge only; no combinational path from input to output.

Reset
REQ-019 Reset=1 at an edge SHALL force state=A_GRN, cnt=0, ped_pend=0, from any state, including mid-phase.
REQ-020 Output values after reset SHALL be: grn_a=1, red_b=1, all other outputs 0.

Structure
REQ-021 A shared package/header SHALL hold the state encoding constants and the default timing parameters.
REQ-022 The phase counter SHALL be one sub-module, semaforo_temporizador, with ports Clock, Reset, clr, cnt.
REQ-023 The controller SHALL instantiate semaforo_temporizador once and hold the state register and ped_pend flop.

Verification
REQ-024 Reset held 3 cycles, then no inputs for 20 cycles -> grn_a=1, red_b=1 every cycle, walk never 1.
REQ-025 CAR_B=1 held from reset release -> sequence:
- grn_a 4 cycles, ylw_a 2, all-red 1;
- grn_b 8 (forced by T_GRN_MAX), ylw_b 2, all-red 1;
- grn_a 4, then the cycle repeats.
REQ-026 Single-cycle PED pulse at cycle 1 of A_GRN, CAR_B=0 -> sequence:
- grn_a 4, ylw_a 2, all-red 1;
- walk 3, all-red 1;
- grn_a held.
REQ-027 CAR_B pulsed for 2 cycles, arriving after A_GRN min -> grn_b lasts exactly 4 cycles, then ylw_b 2, all-red 1, grn_a.
REQ-028 Reset asserted at cycle 5 of B_GRN with ped_pend=1 -> next cycle grn_a=1 and ped_pend=0; with no new inputs, A_GRN holds.
REQ-029 PED=1 on the edge entering WALK, then PED=0 -> ped_pend=0 after that edge; a second WALK occurs only after a new PED pulse.

Source files
------------

// File: rtl/semaforo_cruzamento_ctrl_pkg.sv
// rtl/semaforo_cruzamento_ctrl_pkg.sv - phase encoding, default timings and lamp decode
package semaforo_cruzamento_ctrl_pkg;

  typedef enum logic [2:0] {
    A_GRN, A_YLW, AR_A, WALK, AR_W, B_GRN, B_YLW, AR_B
  } fase_t;

  localparam int T_GRN_MIN_DEF = 4;
  localparam int T_GRN_MAX_DEF = 8;
  localparam int T_YLW_DEF     = 2;
  localparam int T_ALLRED_DEF  = 1;
  localparam int T_WALK_DEF    = 3;
  localparam int CW_DEF        = 8;

  typedef struct packed {
    logic red_a;
    logic ylw_a;
    logic grn_a;
    logic red_b;
    logic ylw_b;
    logic grn_b;
    logic walk;
  } lamps_t;

  // Exactly one lamp per road in every phase; walk only in WALK.
  function automatic lamps_t decode(input fase_t f);
    lamps_t l;
    l = '0;
    case (f)
      A_GRN:   begin l.grn_a = 1'b1; l.red_b = 1'b1; end
      A_YLW:   begin l.ylw_a = 1'b1; l.red_b = 1'b1; end
      B_GRN:   begin l.red_a = 1'b1; l.grn_b = 1'b1; end
      B_YLW:   begin l.red_a = 1'b1; l.ylw_b = 1'b1; end
      WALK:    begin l.red_a = 1'b1; l.red_b = 1'b1; l.walk = 1'b1; end
      default: begin l.red_a = 1'b1; l.red_b = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/semaforo_temporizador.sv
// rtl/semaforo_temporizador.sv - saturating phase counter, cleared on every phase change
module semaforo_temporizador #(
  parameter int CW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge Clock) begin
    if (Reset || clr)
      cnt <= '0;
    else if (cnt != '1)
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/semaforo_cruzamento_ctrl.sv
// rtl/semaforo_cruzamento_ctrl.sv - main/side road crossing controller with pedestrian phase
module semaforo_cruzamento_ctrl
  import semaforo_cruzamento_ctrl_pkg::*;
#(
  parameter int T_GRN_MIN = T_GRN_MIN_DEF,
  parameter int T_GRN_MAX = T_GRN_MAX_DEF,
  parameter int T_YLW     = T_YLW_DEF,
  parameter int T_ALLRED  = T_ALLRED_DEF,
  parameter int T_WALK    = T_WALK_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic CAR_B,
  input  logic PED,
  output logic red_a,
  output logic ylw_a,
  output logic grn_a,
  output logic red_b,
  output logic ylw_b,
  output logic grn_b,
  output logic walk
);

  localparam logic [CW-1:0] GMIN_END = CW'(T_GRN_MIN - 1);
  localparam logic [CW-1:0] GMAX_END = CW'(T_GRN_MAX - 1);
  localparam logic [CW-1:0] YLW_END  = CW'(T_YLW - 1);
  localparam logic [CW-1:0] AR_END   = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] WALK_END = CW'(T_WALK - 1);

  fase_t         state, nxt;
  logic          ped_pend;
  logic          clr;
  logic [CW-1:0] cnt;
  lamps_t        lamps;

  semaforo_temporizador #(.CW(CW)) u_temporizador (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (clr),
    .cnt   (cnt)
  );

  always_comb begin
    nxt = state;
    case (state)
      A_GRN: if (cnt >= GMIN_END && (CAR_B || ped_pend)) nxt = A_YLW;
      A_YLW: if (cnt == YLW_END) nxt = AR_A;
      AR_A:  if (cnt == AR_END) nxt = ped_pend ? WALK : B_GRN;
      WALK:  if (cnt == WALK_END) nxt = AR_W;
      AR_W:  if (cnt == AR_END) nxt = CAR_B ? B_GRN : A_GRN;
      B_GRN: if ((cnt >= GMIN_END && (!CAR_B || ped_pend)) || cnt == GMAX_END) nxt = B_YLW;
      B_YLW: if (cnt == YLW_END) nxt = AR_B;
      AR_B:  if (cnt == AR_END) nxt = A_GRN;
      default: nxt = A_GRN;
    endcase
  end

  assign clr = (nxt != state);

  // Lamps are registered from the next phase so they always equal decode(state).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= A_GRN;
      ped_pend <= 1'b0;
      lamps    <= decode(A_GRN);
    end else begin
      state    <= nxt;
      lamps    <= decode(nxt);
      if (nxt == WALK && state != WALK)
        ped_pend <= 1'b0;
      else if (PED)
        ped_pend <= 1'b1;
    end
  end

  assign red_a = lamps.red_a;
  assign ylw_a = lamps.ylw_a;
  assign grn_a = lamps.grn_a;
  assign red_b = lamps.red_b;
  assign ylw_b = lamps.ylw_b;
  assign grn_b = lamps.grn_b;
  assign walk  = lamps.walk;

endmodule
